// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, oversampling constants and default sizing.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  // Tick index of the start-bit centre, counted from the detected falling edge.
  localparam int START_MID  = 7;

  localparam int DEF_BAUD_DIV  = 326;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_SB_TICKS  = 16;
  localparam int DEF_DIV_BITS  = 9;

endpackage

// File: rtl/baud_gen.sv
// Free-running mod-BaudDiv divider producing a one-clock tick every BaudDiv clocks.
// Shared by the UART receiver and transmitter; never cleared by its users.
module baud_gen #(
  parameter int BaudDiv = 326,
  parameter int DivBits = 9
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam logic [DivBits-1:0] CntLast = DivBits'(BaudDiv - 1);

  logic [DivBits-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CntLast);
    cnt_d  = tick_o ? '0 : cnt_q + DivBits'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART deframer; rx_done_o is a registered 1-clock strobe straight into the RX FIFO, no backpressure.
// UART_RX_PARITY_EN compiles in an even-parity bit and a live parity_err_o; otherwise parity_err_o is tied low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DataBits = DEF_DATA_BITS,
  parameter int SbTicks  = DEF_SB_TICKS,
  parameter int BaudDiv  = DEF_BAUD_DIV,
  parameter int DivBits  = DEF_DIV_BITS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rx_i,
  output logic [DataBits-1:0] rx_data_o,
  output logic                rx_done_o,
  output logic                frame_err_o,
  output logic                parity_err_o
);

  localparam int NW = (DataBits > 1) ? $clog2(DataBits) : 1;

  localparam logic [4:0]    SStartMid = 5'(START_MID);
  localparam logic [4:0]    SBitEnd   = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]    SStopEnd  = 5'(SbTicks - 1);
  localparam logic [NW-1:0] NLast     = NW'(DataBits - 1);

  logic tick;
  logic rx_s;

  logic [1:0] sync_q, sync_d;

  rx_state_e           state_q, state_d;
  logic [4:0]          s_q, s_d;
  logic [NW-1:0]       n_q, n_d;
  logic [DataBits-1:0] b_q, b_d;
  logic [DataBits:0]   shift_in;

  logic [DataBits-1:0] rx_data_q, rx_data_d;
  logic                rx_done_q, rx_done_d;
  logic                frame_err_q, frame_err_d;
  logic                stop_done;

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  logic parity_err_q, parity_err_d;
`endif

  baud_gen #(
    .BaudDiv (BaudDiv),
    .DivBits (DivBits)
  ) u_baud_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  // Resets to 1 so the idle-high line does not look like a start bit after reset.
  assign sync_d = {sync_q[0], rx_i};
  assign rx_s   = sync_q[1];

  assign shift_in  = {rx_s, b_q};
  assign stop_done = (state_q == ST_STOP) && tick && (s_q == SStopEnd);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q      <= 2'b11;
      state_q     <= ST_IDLE;
      s_q         <= '0;
      n_q         <= '0;
      b_q         <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      b_q         <= b_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (s_q == SStartMid) begin
            // High at the start-bit centre means a glitch: drop back silently.
            if (!rx_s) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s_q == SBitEnd) begin
            s_d = '0;
            b_d = shift_in[DataBits:1];
            if (n_q == NLast) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (s_q == SBitEnd) begin
            s_d     = '0;
            perr_d  = ^{b_q, rx_s};
            state_d = ST_STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (s_q == SStopEnd) begin
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frames with a low stop bit are still delivered, flagged via frame_err_o.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (stop_done) begin
      rx_data_d   = b_q;
      rx_done_d   = 1'b1;
      frame_err_d = ~rx_s;
`ifdef UART_RX_PARITY_EN
      parity_err_d = perr_q;
`endif
    end
  end

  assign rx_data_o   = rx_data_q;
  assign rx_done_o   = rx_done_q;
  assign frame_err_o = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BaudDiv=4 (64 clocks per bit); covers parity checks when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int BIT = 64;

  logic       clk;
  logic       rst_i;
  logic       rx_i;
  logic [7:0] rx_data_o;
  logic       rx_done_o;
  logic       frame_err_o;
  logic       parity_err_o;

  int errors = 0;
  int checks = 0;

  int         cyc = 0;
  int         strobe_cnt = 0;
  int         wide_cnt = 0;
  int         done_cyc = 0;
  logic       done_prev = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic       last_ferr = 1'b0;
  logic       last_perr = 1'b0;
  logic [7:0] q_data[$];

  uart_rx #(
    .DataBits (8),
    .SbTicks  (16),
    .BaudDiv  (4),
    .DivBits  (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .rx_i         (rx_i),
    .rx_data_o    (rx_data_o),
    .rx_done_o    (rx_done_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_done_o) begin
      if (done_prev) wide_cnt = wide_cnt + 1;
      strobe_cnt = strobe_cnt + 1;
      last_data  = rx_data_o;
      last_ferr  = frame_err_o;
      last_perr  = parity_err_o;
      done_cyc   = cyc;
      q_data.push_back(rx_data_o);
    end
    done_prev = rx_done_o;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic v, input int clks);
    rx_i = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_ok);
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, BIT);
`endif
    if (stop_ok) begin
      drive_bit(1'b1, BIT);
    end else begin
      // Low through the stop sample point, then back to idle.
      drive_bit(1'b0, 48);
      drive_bit(1'b1, 16);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    rx_i  = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data_o); end
    checks++; if (rx_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", rx_done_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", parity_err_o); end
    rst_i = 1'b0;
    drive_bit(1'b1, 20);
  endtask

  task automatic test_basic;
    int c0;
    int t0;
    int lat;
    c0 = strobe_cnt;
    t0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b1);
    drive_bit(1'b1, 20);
    lat = done_cyc - t0;
    checks++; if (strobe_cnt - c0 !== 1) begin errors++; $display("FAIL basic_count: got %0d want 1", strobe_cnt - c0); end
    checks++; if (last_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", last_data); end
    checks++; if (last_ferr !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b want 0", last_ferr); end
    checks++; if (last_perr !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b want 0", last_perr); end
`ifdef UART_RX_PARITY_EN
    checks++; if (lat < 668 || lat > 680) begin errors++; $display("FAIL basic_latency: got %0d want 668..680", lat); end
`else
    checks++; if (lat < 604 || lat > 616) begin errors++; $display("FAIL basic_latency: got %0d want 604..616", lat); end
`endif
    checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL done_width: got %0d wide strobes want 0", wide_cnt); end
  endtask

  task automatic test_back_to_back;
    int c0;
    c0 = strobe_cnt;
    q_data.delete();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    drive_bit(1'b1, 40);
    checks++; if (strobe_cnt - c0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", strobe_cnt - c0); end
    if (q_data.size() >= 2) begin
      checks++; if (q_data[0] !== 8'h00) begin errors++; $display("FAIL b2b_data0: got %h want 00", q_data[0]); end
      checks++; if (q_data[1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1: got %h want ff", q_data[1]); end
    end
    checks++; if (last_ferr !== 1'b0) begin errors++; $display("FAIL b2b_ferr: got %b want 0", last_ferr); end
  endtask

  task automatic test_frame_err;
    int c0;
    c0 = strobe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    drive_bit(1'b1, 128);
    checks++; if (strobe_cnt - c0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", strobe_cnt - c0); end
    checks++; if (last_data !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h want 3c", last_data); end
    checks++; if (last_ferr !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", last_ferr); end
    c0 = strobe_cnt;
    send_frame(8'h55, 1'b0, 1'b1);
    drive_bit(1'b1, 20);
    checks++; if (strobe_cnt - c0 !== 1) begin errors++; $display("FAIL ferr_next_count: got %0d want 1", strobe_cnt - c0); end
    checks++; if (last_data !== 8'h55) begin errors++; $display("FAIL ferr_next_data: got %h want 55", last_data); end
    checks++; if (last_ferr !== 1'b0) begin errors++; $display("FAIL ferr_next_flag: got %b want 0", last_ferr); end
  endtask

  task automatic test_glitch;
    int c0;
    c0 = strobe_cnt;
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 3 * BIT);
    checks++; if (strobe_cnt - c0 !== 0) begin errors++; $display("FAIL glitch_nostrobe: got %0d want 0", strobe_cnt - c0); end
    c0 = strobe_cnt;
    send_frame(8'h81, 1'b0, 1'b1);
    drive_bit(1'b1, 20);
    checks++; if (strobe_cnt - c0 !== 1) begin errors++; $display("FAIL glitch_next_count: got %0d want 1", strobe_cnt - c0); end
    checks++; if (last_data !== 8'h81) begin errors++; $display("FAIL glitch_next_data: got %h want 81", last_data); end
    checks++; if (last_ferr !== 1'b0) begin errors++; $display("FAIL glitch_next_ferr: got %b want 0", last_ferr); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    send_frame(8'h07, 1'b0, 1'b1);
    drive_bit(1'b1, 20);
    checks++; if (last_data !== 8'h07) begin errors++; $display("FAIL par_bad_data: got %h want 07", last_data); end
    checks++; if (last_perr !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b want 1", last_perr); end
    send_frame(8'h07, 1'b1, 1'b1);
    drive_bit(1'b1, 20);
    checks++; if (last_perr !== 1'b0) begin errors++; $display("FAIL par_good_flag: got %b want 0", last_perr); end
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL par_deassert: got %b want 0", parity_err_o); end
  endtask
`endif

  task automatic test_mid_reset;
    int c0;
    c0 = strobe_cnt;
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, BIT);
    drive_bit(1'b1, BIT);
    drive_bit(1'b0, BIT / 2);
    rst_i = 1'b1;
    rx_i  = 1'b1;
    @(negedge clk);
    checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL mrst_data: got %h want 00", rx_data_o); end
    checks++; if (rx_done_o !== 1'b0) begin errors++; $display("FAIL mrst_done: got %b want 0", rx_done_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL mrst_ferr: got %b want 0", frame_err_o); end
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL mrst_perr: got %b want 0", parity_err_o); end
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    drive_bit(1'b1, 12 * BIT);
    checks++; if (strobe_cnt - c0 !== 0) begin errors++; $display("FAIL mrst_nostrobe: got %0d want 0", strobe_cnt - c0); end
    checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL mrst_hold: got %h want 00", rx_data_o); end
    c0 = strobe_cnt;
    send_frame(8'h5A, 1'b0, 1'b1);
    drive_bit(1'b1, 20);
    checks++; if (strobe_cnt - c0 !== 1) begin errors++; $display("FAIL mrst_next_count: got %0d want 1", strobe_cnt - c0); end
    checks++; if (last_data !== 8'h5A) begin errors++; $display("FAIL mrst_next_data: got %h want 5a", last_data); end
    checks++; if (rx_data_o !== 8'h5A) begin errors++; $display("FAIL mrst_next_hold: got %h want 5a", rx_data_o); end
  endtask

  initial begin
    rst_i = 1'b1;
    rx_i  = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_err();
    test_glitch();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_mid_reset();
    checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL final_width: got %0d wide strobes want 0", wide_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

- Serial receiver front end of the RS232 receive path.
- Oversamples the asynchronous line `rx_i` at 16x the baud rate and deframes one start bit, `DataBits` data bits sent LSB first, an optional parity bit and one stop period.
- Delivers each word with a single-cycle `rx_done_o` strobe that drives the receive FIFO write port directly (`rx_done_o` to the FIFO `wr_i`, `rx_data_o` to the FIFO `w_data_i`).

## Interface
- `DataBits`, default 8: number of data bits per frame.
- `SbTicks`, default 16: stop-period length in oversampling ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `BaudDiv`, default 326: clock cycles per oversampling tick (100 MHz / (19200 x 16)).
- `DivBits`, default 9: width of the tick divider counter; must satisfy 2^DivBits >= BaudDiv.
- `clk_i`, input, 1: system clock.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `rx_i`, input, 1: asynchronous serial line; idles high.
- `rx_data_o`, output, DataBits: last received word; holds its value until the next `rx_done_o`.
- `rx_done_o`, output, 1: one-clock strobe marking a completed frame.
- `frame_err_o`, output, 1: stop bit sampled low; valid in the `rx_done_o` cycle.
- `parity_err_o`, output, 1: parity mismatch; valid in the `rx_done_o` cycle.

## Operation
- **Line synchronizer**
  - `rx_i` passes through a 2-flop synchronizer with reset value 1.
  - All FSM decisions use the synchronized value `rx_s`.
- **Tick generator**
  - Free-running counter from 0 to BaudDiv-1.
  - `tick` is high for one clock when the count equals BaudDiv-1; the counter then wraps to 0.
  - The counter is never cleared by the FSM.
- **FSM registers**
  - State: IDLE, START, DATA, PARITY, STOP.
  - Tick counter `s`, 5 bits (covers SbTicks up to 32).
  - Bit counter `n`, clog2(DataBits) bits.
  - Shift register `b`, DataBits wide.
- **IDLE**: when `rx_s`==0, go to START with `s`=0.
- **START**
  - On each tick, `s`++.
  - On the tick where `s`==7 (mid start bit): if `rx_s`==0, go to DATA with `s`=0 and `n`=0. If `rx_s`==1, treat it as a glitch and return to IDLE with no strobe.
- **DATA**
  - On the tick where `s`==15: set `s`=0 and shift `b` = {`rx_s`, `b`[DataBits-1:1]}.
  - If `n`==DataBits-1, go to PARITY (macro defined) or STOP (macro absent); otherwise `n`++.
  - On every other tick, `s`++.
- **PARITY**
  - On the tick where `s`==15: set `s`=0, register `perr` = ^{`b`, `rx_s`} (even parity expected, so `perr`=1 means mismatch), and go to STOP.
- **STOP**
  - On the tick where `s`==SbTicks-1, in the same cycle:
    - copy `b` to `rx_data_o`;
    - pulse `rx_done_o`;
    - set `frame_err_o` = ~`rx_s` and `parity_err_o` = `perr`;
    - return to IDLE.
  - A frame with a framing error still strobes `rx_done_o`; the consumer decides what to do with it.
- **Strobe and flags**
  - `rx_done_o`, `frame_err_o` and `parity_err_o` are registered and deassert in the following cycle.
  - `rx_data_o` is registered and holds its value.
- **Boundary conditions**
  - A new start bit is accepted in the first IDLE cycle after STOP, so back-to-back frames are not lost.
  - A line held low permanently produces repeated frames with `rx_data_o`=0 and `frame_err_o`=1.
  - Reset asserted mid-frame aborts the frame immediately; no strobe is issued.
- **Reset values**
  - FSM state IDLE; `s`, `n`, `b` = 0.
  - `rx_data_o` = 0, `rx_done_o` = 0, `frame_err_o` = 0, `parity_err_o` = 0.
  - Synchronizer flops = 1; divider count = 0.

## Timing
- Input synchronizer latency: 2 clocks.
- Start-bit qualification: 8 ticks after `rx_s` falls.
- Falling start edge to `rx_done_o`: 2 clocks + (8 + 16·DataBits + 16·P + SbTicks) ticks ±1 tick, where P = 1 with the macro defined and 0 without.
- Data bits are sampled at tick 8 of each bit period (bit center).
- Baud error tolerance: ±2% cumulative across the frame.
- `rx_done_o` is exactly 1 clock wide. The FIFO write data is `rx_data_o` in that same cycle.
- No backpressure: the consumer must accept every strobe. Overflow handling belongs to the FIFO.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined**
  - PARITY state is compiled in.
  - Frame is start + DataBits + even-parity bit + stop.
  - `parity_err_o` reports a mismatch.
- **Undefined**
  - PARITY state and `perr` are removed; DATA goes directly to STOP.
  - `parity_err_o` is tied to 0.
  - The port list is identical in both builds.

## Structure
- **Shared package** `uart_pkg`:
  - FSM state encoding typedef (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - `OVERSAMPLE` = 16;
  - `START_MID` = 7;
  - default `BaudDiv` and `DataBits` constants.
- **Sub-module** `baud_gen`: parameterized mod-BaudDiv tick counter.
  - Ports: `clk_i`, `rst_i`, `tick_o`.
  - The UART transmitter reuses it.

## Test plan
Use BaudDiv=4 for simulation.
- Frame 0xA5, parity bit 0, stop bit 1 -> one `rx_done_o` pulse; `rx_data_o`=0xA5; `frame_err_o`=0; `parity_err_o`=0.
- Back-to-back frames 0x00 then 0xFF with zero idle time -> two strobes carrying 0x00 and 0xFF, none dropped.
- Frame 0x3C with stop bit driven 0 -> strobe with `rx_data_o`=0x3C and `frame_err_o`=1; the next good frame 0x55 has `frame_err_o`=0.
- Line low for 4 ticks, then high -> no strobe; FSM back in IDLE; a following frame 0x81 is received correctly.
- With `UART_RX_PARITY_EN` defined, frame 0x07 sent with parity bit 0 -> `parity_err_o`=1; resent with parity 1 -> `parity_err_o`=0.
- `rst_i` pulsed during the DATA state of frame 0xC3 -> no strobe; all outputs 0; a fresh frame 0x5A afterward yields 0x5A.
